// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - time-multiplexed 8-digit 7-segment scanner with anti-ghosting blank gap
module display_scanner #(
   parameter int unsigned SCAN_DIV  = 100000,
   parameter int unsigned BLANK_CYC = 1000,
   parameter bit          LZ_BLANK  = 1'b1
) (
   input  logic       clk_1,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [3:0] CSEG0_i,
   input  logic [3:0] CSEG1_i,
   input  logic [3:0] SEG0_i,
   input  logic [3:0] SEG1_i,
   input  logic [3:0] MIN0_i,
   input  logic [3:0] MIN1_i,
   input  logic [3:0] HOUR0_i,
   input  logic [3:0] HOUR1_i,
   output logic [7:0] an_o,
   output logic [6:0] seg_o,
   output logic       dp_o,
   output logic       frame_o
);

   localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } phase_t;

   phase_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;
   logic            frame_q, frame_d;

   logic [3:0]      digit;
   logic            slot_end;
   logic            lz_hide;
   logic            drive;

   // Active-low segments, bit6 = g ... bit0 = a; invalid BCD shows a dash.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   always_comb begin
      case (idx_q)
         3'd0:    digit = CSEG0_i;
         3'd1:    digit = CSEG1_i;
         3'd2:    digit = SEG0_i;
         3'd3:    digit = SEG1_i;
         3'd4:    digit = MIN0_i;
         3'd5:    digit = MIN1_i;
         3'd6:    digit = HOUR0_i;
         default: digit = HOUR1_i;
      endcase
   end

   always_comb begin
      slot_end = (cnt_q == CNT_LAST);
      cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
      idx_d    = slot_end ? idx_q + 3'd1 : idx_q;
      frame_d  = slot_end && (idx_q == 3'd7);

      state_d = state_q;
      case (state_q)
         ST_BLANK: if (cnt_q == BLANK_END) state_d = ST_DRIVE;
         ST_DRIVE: if (slot_end)           state_d = ST_BLANK;
         default:                          state_d = ST_BLANK;
      endcase

      // Scanning keeps running while dark; only the pins are gated here.
      lz_hide = LZ_BLANK && (idx_q == 3'd7) && (HOUR1_i == 4'd0);
      drive   = (state_q == ST_DRIVE) && en_i && !lz_hide;

      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (drive) begin
         an_d  = ~(8'd1 << idx_q);
         seg_d = bcd_to_seg(digit);
         dp_d  = !((idx_q == 3'd2) || (idx_q == 3'd4) || (idx_q == 3'd6));
      end
   end

   always_ff @(posedge clk_1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BLANK;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         an_q    <= 8'hFF;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         frame_q <= frame_d;
      end
   end

   assign an_o    = an_q;
   assign seg_o   = seg_q;
   assign dp_o    = dp_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - directed bench with a time-based model of the scan and literal spot checks
module tb_display_scanner;

   localparam int SD = 8;
   localparam int BC = 2;
   localparam bit LZ = 1'b1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic [3:0] dig [8];
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame;

   int total = 0;
   int bad = 0;

   // Model: outputs after edge n follow from the cycle index t = n-1 since reset.
   int         t_m;
   logic [7:0] exp_an;
   logic [6:0] exp_seg;
   logic       exp_dp;
   logic       exp_frame;

   logic [6:0] seg_tab [16];

   display_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(LZ)) dut (
      .clk_1(clk), .rst_n(rst_n), .en_i(en),
      .CSEG0_i(dig[0]), .CSEG1_i(dig[1]), .SEG0_i(dig[2]), .SEG1_i(dig[3]),
      .MIN0_i(dig[4]), .MIN1_i(dig[5]), .HOUR0_i(dig[6]), .HOUR1_i(dig[7]),
      .an_o(an), .seg_o(seg), .dp_o(dp), .frame_o(frame)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_m       <= 0;
         exp_an    <= 8'hFF;
         exp_seg   <= 7'h7F;
         exp_dp    <= 1'b1;
         exp_frame <= 1'b0;
      end else begin
         int  slot, ph;
         bit  lit;
         slot = (t_m / SD) % 8;
         ph   = t_m % SD;
         lit  = (ph >= BC) && en && !(LZ && slot == 7 && dig[7] == 4'd0);
         exp_an    <= lit ? ~(8'd1 << slot) : 8'hFF;
         exp_seg   <= lit ? seg_tab[dig[slot]] : 7'h7F;
         exp_dp    <= lit ? !(slot == 2 || slot == 4 || slot == 6) : 1'b1;
         exp_frame <= (t_m % (8 * SD)) == (8 * SD - 1);
         t_m       <= t_m + 1;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0d)", name, act, req, t_m);
      end
   endtask

   always @(negedge clk) begin
      chk("model_an", an, exp_an);
      chk("model_seg", {1'b0, seg}, {1'b0, exp_seg});
      chk("model_dp", {7'd0, dp}, {7'd0, exp_dp});
      chk("model_frame", {7'd0, frame}, {7'd0, exp_frame});
      chk("onehot_an", {7'd0, $countones(~an) <= 1}, 8'd1);
   end

   task automatic goto(input int n);
      int k = 0;
      while (t_m != n && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (t_m != n) begin
         total++;
         bad++;
         $display("FAIL goto: reached %0d expected %0d", t_m, n);
      end
   endtask

   initial begin
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                  7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
      for (int i = 0; i < 8; i++) dig[i] = 4'(i + 1);
      repeat (3) @(negedge clk);
      chk("rst_an", an, 8'hFF);
      chk("rst_seg", {1'b0, seg}, 8'h7F);
      chk("rst_frame", {7'd0, frame}, 8'd0);
      rst_n = 1'b1;

      goto(2);   chk("lit_blank2", an, 8'hFF);
      goto(3);   chk("lit_first_an", an, 8'hFE);
                 chk("lit_first_seg", {1'b0, seg}, {1'b0, 7'b1111001});
      goto(8);   chk("lit_slot0_end", an, 8'hFE);
      goto(9);   chk("lit_gap", an, 8'hFF);
      goto(20);  chk("lit_dp_an", an, 8'hFB);
                 chk("lit_dp", {7'd0, dp}, 8'd0);
      goto(28);  chk("lit_nodp", {7'd0, dp}, 8'd1);
      goto(60);  chk("lit_d7_an", an, 8'h7F);
                 chk("lit_d7_seg", {1'b0, seg}, {1'b0, 7'b0000000});
      goto(64);  chk("lit_frame", {7'd0, frame}, 8'd1);
      goto(65);  chk("lit_frame_off", {7'd0, frame}, 8'd0);

      goto(70);  en = 1'b0;
      goto(71);  chk("lit_en_off_an", an, 8'hFF);
                 chk("lit_en_off_seg", {1'b0, seg}, 8'h7F);
      goto(110); en = 1'b1;
      goto(111); chk("lit_en_on_an", an, 8'hDF);
                 chk("lit_en_on_seg", {1'b0, seg}, {1'b0, 7'b0000010});
      goto(128); chk("lit_frame2", {7'd0, frame}, 8'd1);

      goto(130); dig[7] = 4'd0; dig[4] = 4'hC;
      goto(164); chk("lit_inv_an", an, 8'hEF);
                 chk("lit_inv_seg", {1'b0, seg}, {1'b0, 7'b0111111});
      goto(188); chk("lit_lz_an", an, 8'hFF);
      goto(192); dig[7] = 4'd1;
      goto(252); chk("lit_h1_an", an, 8'h7F);
                 chk("lit_h1_seg", {1'b0, seg}, {1'b0, 7'b1111001});

      goto(284); chk("lit_pre_rst", an, 8'hF7);
      #1 rst_n = 1'b0;
      #1;
      chk("lit_async_an", an, 8'hFF);
      chk("lit_async_seg", {1'b0, seg}, 8'h7F);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      goto(1);   chk("lit_rr1", an, 8'hFF);
      goto(2);   chk("lit_rr2", an, 8'hFF);
      goto(3);   chk("lit_rr3", an, 8'hFE);
      goto(70);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed driver for the 8-digit common-anode 7-segment display of the chronometer. It sits directly downstream of the display manager and consumes the eight latched BCD digits (centiseconds, seconds, minutes, hours) plus its `display_en` blink/enable. It scans one digit at a time, decodes BCD to active-low segments and inserts an anti-ghosting blank gap at every digit change. It drives the board anode and segment pins from registers.

## Interface
- `SCAN_DIV`, 100000: clock cycles per digit slot. Legal range 2..2^20.
- `BLANK_CYC`, 1000: cycles at the start of each slot with all anodes off. Legal range 1..SCAN_DIV-1.
- `LZ_BLANK`, 1: when 1, `HOUR1_i` = 0 is not displayed (leading-zero suppression).
- `clk_1` in 1: single system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en_i` in 1: display enable from the display manager, synchronous to `clk_1`. When 0 the display is dark.
- `CSEG0_i`, `CSEG1_i`, `SEG0_i`, `SEG1_i`, `MIN0_i`, `MIN1_i`, `HOUR0_i`, `HOUR1_i` in 4 each: BCD digits, least-significant first.
- `an_o` out 8: anode enables, active-low; bit k selects digit k.
- `seg_o` out 7: segments, active-low; bit0 = a … bit6 = g.
- `dp_o` out 1: decimal point, active-low.
- `frame_o` out 1: one-cycle pulse when the scan wraps from digit 7 to digit 0.

## Operation
- **Internal state:**
  - slot counter `cnt`: 0..SCAN_DIV-1, width clog2(SCAN_DIV).
  - digit index `idx`: 3 bits, wraps 7→0.
  - phase FSM with states BLANK and DRIVE.
- **Counter and index stepping:**
  - `cnt` increments every cycle.
  - At `cnt` = SCAN_DIV-1, `cnt` goes to 0 and `idx` goes to `idx`+1 mod 8.
  - The 7→0 transition of `idx` asserts `frame_o` for exactly one cycle.
- **FSM transitions:**
  - BLANK → DRIVE when `cnt` = BLANK_CYC-1.
  - DRIVE → BLANK when `cnt` = SCAN_DIV-1.
  - No other transitions.
- **Digit map:**

  | idx | digit |
  |---|---|
  | 0 | CSEG0 |
  | 1 | CSEG1 |
  | 2 | SEG0 |
  | 3 | SEG1 |
  | 4 | MIN0 |
  | 5 | MIN1 |
  | 6 | HOUR0 |
  | 7 | HOUR1 |

  `dp_o` = 0 (lit) only while driving idx 2, 4 or 6, separating cs/s/min/h.
- **Decode (active-low, g..a order):**

  | Digit | Pattern |
  |---|---|
  | 0 | 1000000 |
  | 1 | 1111001 |
  | 2 | 0100100 |
  | 3 | 0110000 |
  | 4 | 0011001 |
  | 5 | 0010010 |
  | 6 | 0000010 |
  | 7 | 1111000 |
  | 8 | 0000000 |
  | 9 | 0010000 |
  | 10..15 (invalid) | 0111111 (segment g only, "-") |

- **Drive condition:** `an_o[idx]` = 0 and decoded `seg_o`/`dp_o` are presented only when all of the following hold:
  - FSM is in DRIVE;
  - `en_i` = 1;
  - not (LZ_BLANK = 1, idx = 7 and `HOUR1_i` = 0).
- **Otherwise:** `an_o` = 8'hFF, `seg_o` = 7'h7F, `dp_o` = 1.
- **Behaviour while dark:** scanning (`cnt`, `idx`, FSM, `frame_o`) continues regardless of `en_i` and leading-zero suppression; only the pins are blanked.
- **Digit inputs:** sampled live every cycle. A change mid-slot appears on `seg_o` on the next cycle; no internal latching, because the manager holds the inputs stable.
- **One-hot anodes:** at most one bit of `an_o` is 0 at any time.

## Timing
- **Reset (asynchronous, `rst_n` = 0):**
  - Internal state: `cnt` = 0, `idx` = 0, FSM = BLANK.
  - Outputs: `an_o` = 8'hFF, `seg_o` = 7'h7F, `dp_o` = 1, `frame_o` = 0.
  - Applies immediately, including mid-slot; the scan restarts at digit 0, BLANK.
- **Latency:** all outputs are registered. Outputs in cycle t+1 are a function of `cnt`, `idx`, FSM, `en_i` and the digit inputs in cycle t.
- **Slot timing:** per slot, anodes are off for BLANK_CYC cycles, then one anode is low for SCAN_DIV-BLANK_CYC consecutive cycles.
- **Frame period:** 8·SCAN_DIV cycles. `frame_o` pulses once per frame, in the cycle after the last DRIVE cycle of idx 7.
- **`en_i` edges:** a 1→0 edge darkens `an_o` one cycle later; a 0→1 edge mid-DRIVE lights the current digit one cycle later for the remainder of the slot.
- **Gap between digits:** there is never a cycle in which two digits, or the same anode across a digit change, are driven without the BLANK gap.

## Test plan
All scenarios use SCAN_DIV = 8, BLANK_CYC = 2, LZ_BLANK = 1.
1. **Reset and scan order.** Release reset with `en_i` = 1 and digits 1,2,3,4,5,6,7,8 (CSEG0..HOUR1). Required:
   - `an_o` cycles FE, FD, FB … 7F, each low 6 cycles and separated by 2 cycles of FF;
   - `seg_o` = 1111001 during digit 0 and 0000000 during digit 7;
   - `frame_o` pulses every 64 cycles.
2. **Decimal point.** Same stimulus as scenario 1. Required: `dp_o` = 0 only while `an_o` = FB, EF or BF; 1 at all other times.
3. **Enable gating.** Drive `en_i` = 0 for 40 cycles mid-frame. Required:
   - `an_o` = FF and `seg_o` = 7F one cycle after the fall;
   - `frame_o` timing unchanged;
   - display resumes on the correct digit one cycle after `en_i` rises.
4. **Leading-zero suppression.** Set `HOUR1_i` = 0. Required: `an_o[7]` never 0 and the slot stays FF. With `HOUR1_i` = 1, `an_o` = 7F is driven with `seg_o` = 1111001.
5. **Invalid BCD.** Set `MIN0_i` = 4'hC. Required: `seg_o` = 0111111 while `an_o` = EF.
6. **Mid-operation reset.** Assert `rst_n` = 0 while `an_o` = F7. Required:
   - `an_o` = FF and `seg_o` = 7F asynchronously;
   - after release, 2 blank cycles, then `an_o` = FE.
